// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg: shared FSM states, mode encoding and channel-index width helper
package scan_mux_pkg;
  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_e;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  function automatic int idx_w(int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/scan_mux_if.sv
// scan_mux_if: channel data, controls and registered outputs of scan_mux
interface scan_mux_if #(parameter int WIDTH = 4, parameter int CHANNELS = 4);
  localparam int IW = scan_mux_pkg::idx_w(CHANNELS);
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [IW-1:0] sel;
  logic mode;
  logic enable;
  logic [WIDTH-1:0] y;
  logic [IW-1:0] active_ch;
  logic valid;
  modport master (output data_in, sel, mode, enable, input y, active_ch, valid);
  modport slave (input data_in, sel, mode, enable, output y, active_ch, valid);
endinterface

// File: rtl/scan_mux_ch_decoder.sv
// ch_decoder: channel index to one-hot select plus in-range flag
module ch_decoder #(
  parameter int CHANNELS = 4,
  parameter int IW = 2
) (
  input  logic [IW-1:0]       idx,
  output logic [CHANNELS-1:0] onehot,
  output logic                in_range
);
  always_comb begin
    onehot = '0;
    for (int k = 0; k < CHANNELS; k++) onehot[k] = int'(idx) == k;
    in_range = |onehot;
  end
endmodule

// File: rtl/scan_mux.sv
// scan_mux: registered manual/scanning channel multiplexer with per-channel dwell
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL = 4
) (
  input logic       clk,
  input logic       rst_n,
  scan_mux_if.slave bus
);
  localparam int IW = idx_w(CHANNELS);
  state_e state_q, state_d;
  logic [IW-1:0] ch_q, ch_d, idx, scan_ch;
  logic [7:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d, pick;
  logic valid_q, valid_d, wrap, in_range;
  logic [CHANNELS-1:0] onehot;
  always_comb begin
    state_d = !bus.enable ? IDLE : bus.mode == MODE_MANUAL ? MANUAL : SCAN;
    wrap = state_q == SCAN && cnt_q == 8'(DWELL - 1);
    scan_ch = !wrap ? ch_q : ch_q == IW'(CHANNELS - 1) ? '0 : ch_q + 1'b1;
    idx = state_d == MANUAL ? bus.sel : scan_ch;
  end
  ch_decoder #(.CHANNELS(CHANNELS), .IW(IW)) u_dec (
    .idx      (idx),
    .onehot   (onehot),
    .in_range (in_range)
  );
  // first SCAN cycle after any other state keeps the channel and restarts the dwell
  always_comb begin
    pick = '0;
    for (int k = 0; k < CHANNELS; k++) pick |= bus.data_in[k*WIDTH +: WIDTH] & {WIDTH{onehot[k]}};
    valid_d = state_d != IDLE && in_range;
    y_d = valid_d ? pick : '0;
    ch_d = valid_d ? idx : ch_q;
    cnt_d = state_d == SCAN && state_q == SCAN && !wrap ? cnt_q + 8'd1 : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q <= '0;
      cnt_q <= '0;
      y_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      cnt_q <= cnt_d;
      y_q <= y_d;
      valid_q <= valid_d;
    end
  end
  assign bus.y = y_q;
  assign bus.active_ch = ch_q;
  assign bus.valid = valid_q;
endmodule
